// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-requester memory bus arbiter.
// Holds FSM state, grant and op encodings used by mem_arb and arb_rr2.
// No logic; types and constants only.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    // Grant index doubles as the request/grant vector bit position
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int ADDR_W = 64;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: one-hot grant from a 2-bit request vector.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is consumed.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  gnt_t       last,
    output logic [1:0] gnt
);

    // Sole requester wins; on a tie the side not granted last wins
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == GNT_D) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arb.sv
// I/D line-refill arbiter onto one downstream bus, one transaction in flight.
// Latency: m_* from t+1 after request, *_dv one cycle after m_ack (min 2 cycles).
// Backpressure: requests held as levels; only accepted in IDLE, watchdog aborts hangs.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int I_LINE  = 256,
    parameter int D_LINE  = 256,
    parameter int M_LINE  = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rd,
    output logic [I_LINE-1:0] i_data,
    output logic              i_dv,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [D_LINE-1:0] d_wdata,
    output logic [D_LINE-1:0] d_rdata,
    output logic              d_dv,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_rd,
    output logic              m_wr,
    output logic [M_LINE-1:0] m_wdata,
    input  logic [M_LINE-1:0] m_rdata,
    input  logic              m_ack,
    output logic              err,
    output logic              busy
);

    localparam int             WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t      state;
    gnt_t            last;
    gnt_t            owner;
    logic [WD_W-1:0] wd;
    logic            dropped;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       owner_req;
    logic       live;
    logic       wd_expire;
    op_t        d_op;

    assign req       = {d_rd | d_wr, i_rd};
    assign d_op      = d_wr ? OP_WR : OP_RD;
    assign owner_req = (owner == GNT_I) ? i_rd : (d_rd | d_wr);
    // A requester that let go at any point during BUSY gets no completion
    assign live      = owner_req & ~dropped;
    assign wd_expire = (wd == WD_LAST);

    arb_rr2 u_rr (
        .req  (req),
        .last (last),
        .gnt  (gnt)
    );

    // Arbiter FSM with all bus and completion outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            last    <= GNT_I;
            owner   <= GNT_I;
            wd      <= '0;
            dropped <= 1'b0;
            i_data  <= '0;
            i_dv    <= 1'b0;
            d_rdata <= '0;
            d_dv    <= 1'b0;
            m_addr  <= '0;
            m_rd    <= 1'b0;
            m_wr    <= 1'b0;
            m_wdata <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        state   <= ARB_BUSY;
                        busy    <= 1'b1;
                        wd      <= '0;
                        dropped <= 1'b0;
                        if (gnt[GNT_D]) begin
                            owner   <= GNT_D;
                            last    <= GNT_D;
                            m_addr  <= d_addr;
                            m_wdata <= M_LINE'(d_wdata);
                            m_wr    <= (d_op == OP_WR);
                            m_rd    <= (d_op == OP_RD);
                        end else begin
                            owner   <= GNT_I;
                            last    <= GNT_I;
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                            m_wr    <= 1'b0;
                            m_rd    <= 1'b1;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (m_ack || wd_expire) begin
                        state <= ARB_RESP;
                        m_rd  <= 1'b0;
                        m_wr  <= 1'b0;
                        if (live) begin
                            // An ack in the expiry cycle still counts as a normal completion
                            err <= ~m_ack;
                            if (owner == GNT_I) begin
                                i_dv   <= 1'b1;
                                i_data <= m_ack ? m_rdata[I_LINE-1:0] : '0;
                            end else begin
                                d_dv    <= 1'b1;
                                d_rdata <= m_ack ? m_rdata[D_LINE-1:0] : '0;
                            end
                        end
                    end else begin
                        wd <= wd + 1'b1;
                        if (!owner_req) begin
                            dropped <= 1'b1;
                        end
                    end
                end
                ARB_RESP: begin
                    // Requests are ignored here: the owner still holds its level during dv
                    state   <= ARB_IDLE;
                    busy    <= 1'b0;
                    i_dv    <= 1'b0;
                    d_dv    <= 1'b0;
                    err     <= 1'b0;
                    i_data  <= '0;
                    d_rdata <= '0;
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
